// File: rtl/regfile_write_queue.sv
// Write queue feeding the 32x8 register file port, with read-after-write bypass for decode.
// Optional feature: define RFWQ_BYPASS_EN to return bypass data; otherwise only hit flags are reported.
module regfile_write_queue #(
  parameter int DEPTH    = 4,
  parameter int PTR_W    = 2,
  parameter int MATCH_W  = 5,
  parameter int FLAG_REG = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic [7:0]       inAddr,
  input  logic [7:0]       inData,
  input  logic [6:0]       inFlags,
  input  logic             hold,
  output logic [7:0]       A3,
  output logic [7:0]       WriteData,
  output logic [6:0]       Flag_input,
  output logic             regWriteEnable,
  input  logic [7:0]       rdAddr1,
  input  logic [7:0]       rdAddr2,
  output logic             byp1Hit,
  output logic             byp2Hit,
  output logic [7:0]       byp1Data,
  output logic [7:0]       byp2Data,
  output logic [PTR_W:0]   count,
  output logic             empty
);

  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, STALL = 2'd2} state_t;

  logic [7:0]       q_addr  [DEPTH];
  logic [7:0]       q_data  [DEPTH];
  logic [6:0]       q_flags [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count_next;
  logic             push;
  logic             pop;
  state_t           state;
  state_t           state_next;

  assign inReady = (count != (PTR_W+1)'(DEPTH));
  assign empty   = (count == {(PTR_W+1){1'b0}}) && !regWriteEnable;
  assign push    = inValid && inReady;
  assign pop     = !hold && (count != {(PTR_W+1){1'b0}});

  // Queue storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= {PTR_W{1'b0}};
      tail  <= {PTR_W{1'b0}};
      count <= {(PTR_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        q_addr[i]  <= 8'h00;
        q_data[i]  <= 8'h00;
        q_flags[i] <= 7'h00;
      end
    end else begin
      if (push) begin
        q_addr[tail]  <= inAddr;
        q_data[tail]  <= inData;
        q_flags[tail] <= inFlags;
        tail          <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      count <= count_next;
    end
  end

  // Register file write stage: strobe is a single-cycle pulse per popped entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      A3             <= 8'h00;
      WriteData      <= 8'h00;
      Flag_input     <= 7'h00;
      regWriteEnable <= 1'b0;
    end else if (pop) begin
      A3             <= q_addr[head];
      WriteData      <= q_data[head];
      Flag_input     <= q_flags[head];
      regWriteEnable <= 1'b1;
    end else begin
      regWriteEnable <= 1'b0;
    end
  end

  // Drain FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Occupancy update and drain FSM next state
  always_comb begin
    count_next = count;
    state_next = state;
    case ({push, pop})
      2'b10:   count_next = count + (PTR_W+1)'(1);
      2'b01:   count_next = count - (PTR_W+1)'(1);
      default: count_next = count;
    endcase
    case (state)
      IDLE: begin
        if (push) begin
          state_next = hold ? STALL : DRAIN;
        end else begin
          state_next = IDLE;
        end
      end
      DRAIN: begin
        if (hold) begin
          state_next = STALL;
        end else if (count_next == {(PTR_W+1){1'b0}}) begin
          state_next = IDLE;
        end else begin
          state_next = DRAIN;
        end
      end
      STALL: begin
        if (hold) begin
          state_next = STALL;
        end else if (count_next == {(PTR_W+1){1'b0}}) begin
          state_next = IDLE;
        end else begin
          state_next = DRAIN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef RFWQ_BYPASS_EN
  // Oldest-to-youngest scan so the youngest matching write is left in val; reading
  // the flag register hits every pending write and returns its flags.
  function automatic logic [8:0] bypass_lookup(input logic [7:0] rd);
    logic             hit;
    logic [7:0]       val;
    logic             flag_sel;
    logic [PTR_W-1:0] idx;
    flag_sel = (rd == 8'(FLAG_REG));
    hit      = 1'b0;
    val      = 8'h00;
    if (regWriteEnable && (flag_sel || (A3[MATCH_W-1:0] == rd[MATCH_W-1:0]))) begin
      hit = 1'b1;
      val = flag_sel ? {1'b0, Flag_input} : WriteData;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (((PTR_W+1)'(i) < count) &&
          (flag_sel || (q_addr[idx][MATCH_W-1:0] == rd[MATCH_W-1:0]))) begin
        hit = 1'b1;
        val = flag_sel ? {1'b0, q_flags[idx]} : q_data[idx];
      end
    end
    return {hit, val};
  endfunction

  assign {byp1Hit, byp1Data} = bypass_lookup(rdAddr1);
  assign {byp2Hit, byp2Data} = bypass_lookup(rdAddr2);
`else
  function automatic logic bypass_hit(input logic [7:0] rd);
    logic             hit;
    logic             flag_sel;
    logic [PTR_W-1:0] idx;
    flag_sel = (rd == 8'(FLAG_REG));
    hit      = regWriteEnable && (flag_sel || (A3[MATCH_W-1:0] == rd[MATCH_W-1:0]));
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (((PTR_W+1)'(i) < count) &&
          (flag_sel || (q_addr[idx][MATCH_W-1:0] == rd[MATCH_W-1:0]))) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

  assign byp1Hit  = bypass_hit(rdAddr1);
  assign byp2Hit  = bypass_hit(rdAddr2);
  assign byp1Data = 8'h00;
  assign byp2Data = 8'h00;
`endif

endmodule

// File: tb/tb_regfile_write_queue.sv
// Self-checking bench for regfile_write_queue: directed vector table, hand sequences
// for full/reset corners, then random traffic against a queue-based reference model.
module tb_regfile_write_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       inValid;
  logic       inReady;
  logic [7:0] inAddr;
  logic [7:0] inData;
  logic [6:0] inFlags;
  logic       hold;
  logic [7:0] A3;
  logic [7:0] WriteData;
  logic [6:0] Flag_input;
  logic       regWriteEnable;
  logic [7:0] rdAddr1;
  logic [7:0] rdAddr2;
  logic       byp1Hit;
  logic       byp2Hit;
  logic [7:0] byp1Data;
  logic [7:0] byp2Data;
  logic [2:0] count;
  logic       empty;

  int errors = 0;
  int checks = 0;

  regfile_write_queue dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
    .inAddr(inAddr), .inData(inData), .inFlags(inFlags), .hold(hold),
    .A3(A3), .WriteData(WriteData), .Flag_input(Flag_input),
    .regWriteEnable(regWriteEnable), .rdAddr1(rdAddr1), .rdAddr2(rdAddr2),
    .byp1Hit(byp1Hit), .byp2Hit(byp2Hit), .byp1Data(byp1Data), .byp2Data(byp2Data),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;   logic [7:0] a;   logic [7:0] d;  logic [6:0] f;  logic h;
    logic [7:0] r1;  logic [7:0] r2;
    logic       we;  logic [7:0] a3;  logic [7:0] wd; logic [6:0] fl;
    logic [2:0] cnt; logic rdy; logic emp;
    logic       h1;  logic [7:0] d1;  logic h2;       logic [7:0] d2;
  } vec_t;

  typedef struct {
    logic [7:0] a; logic [7:0] d; logic [6:0] f;
  } ent_t;

  ent_t       mq[$];
  logic       m_we;
  logic [7:0] m_a3;
  logic [7:0] m_wd;
  logic [6:0] m_fl;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Bypass data is only returned when the feature is compiled in.
  function automatic logic [7:0] bd(input logic [7:0] d);
`ifdef RFWQ_BYPASS_EN
    return d;
`else
    return 8'h00 & d;
`endif
  endfunction

  // Reference lookup: walk pending writes youngest first, then the write stage.
  task automatic model_byp(input logic [7:0] rd, output logic hit, output logic [7:0] val);
    logic fs;
    fs  = (rd == 8'h03);
    hit = 1'b0;
    val = 8'h00;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!hit && (fs || mq[i].a[4:0] == rd[4:0])) begin
        hit = 1'b1;
        val = fs ? {1'b0, mq[i].f} : mq[i].d;
      end
    end
    if (!hit && m_we && (fs || m_a3[4:0] == rd[4:0])) begin
      hit = 1'b1;
      val = fs ? {1'b0, m_fl} : m_wd;
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] d,
                       input logic [6:0] f, input logic h, input logic [7:0] r1, input logic [7:0] r2);
    inValid = v; inAddr = a; inData = d; inFlags = f; hold = h; rdAddr1 = r1; rdAddr2 = r2;
  endtask

  vec_t tbl[18];

  initial begin
    logic       eh1, eh2, pu, po;
    logic [7:0] ed1, ed2;
    ent_t       e;

    tbl[0]  = '{1'b0,8'h00,8'h00,7'h00,1'b0,8'h00,8'h00, 1'b0,8'h00,8'h00,7'h00,3'd0,1'b1,1'b1,1'b0,8'h00,1'b0,8'h00};
    tbl[1]  = '{1'b1,8'h05,8'hAA,7'h7F,1'b0,8'h05,8'h03, 1'b0,8'h00,8'h00,7'h00,3'd0,1'b1,1'b1,1'b0,8'h00,1'b0,8'h00};
    tbl[2]  = '{1'b0,8'h00,8'h00,7'h00,1'b0,8'h05,8'h03, 1'b0,8'h00,8'h00,7'h00,3'd1,1'b1,1'b0,1'b1,8'hAA,1'b1,8'h7F};
    tbl[3]  = '{1'b0,8'h00,8'h00,7'h00,1'b0,8'h05,8'h03, 1'b1,8'h05,8'hAA,7'h7F,3'd0,1'b1,1'b0,1'b1,8'hAA,1'b1,8'h7F};
    tbl[4]  = '{1'b0,8'h00,8'h00,7'h00,1'b0,8'h05,8'h06, 1'b0,8'h05,8'hAA,7'h7F,3'd0,1'b1,1'b1,1'b0,8'h00,1'b0,8'h00};
    tbl[5]  = '{1'b1,8'h01,8'h11,7'h01,1'b1,8'h0A,8'h2A, 1'b0,8'h05,8'hAA,7'h7F,3'd0,1'b1,1'b1,1'b0,8'h00,1'b0,8'h00};
    tbl[6]  = '{1'b1,8'h02,8'h22,7'h02,1'b1,8'h0A,8'h2A, 1'b0,8'h05,8'hAA,7'h7F,3'd1,1'b1,1'b0,1'b0,8'h00,1'b0,8'h00};
    tbl[7]  = '{1'b1,8'h0A,8'h33,7'h04,1'b1,8'h0A,8'h2A, 1'b0,8'h05,8'hAA,7'h7F,3'd2,1'b1,1'b0,1'b0,8'h00,1'b0,8'h00};
    tbl[8]  = '{1'b1,8'h0A,8'h44,7'h08,1'b1,8'h0A,8'h2A, 1'b0,8'h05,8'hAA,7'h7F,3'd3,1'b1,1'b0,1'b1,8'h33,1'b1,8'h33};
    tbl[9]  = '{1'b1,8'h0F,8'h55,7'h10,1'b1,8'h0A,8'h2A, 1'b0,8'h05,8'hAA,7'h7F,3'd4,1'b0,1'b0,1'b1,8'h44,1'b1,8'h44};
    tbl[10] = '{1'b0,8'h00,8'h00,7'h00,1'b0,8'h03,8'h02, 1'b0,8'h05,8'hAA,7'h7F,3'd4,1'b0,1'b0,1'b1,8'h08,1'b1,8'h22};
    tbl[11] = '{1'b0,8'h00,8'h00,7'h00,1'b0,8'h01,8'h0F, 1'b1,8'h01,8'h11,7'h01,3'd3,1'b1,1'b0,1'b1,8'h11,1'b0,8'h00};
    tbl[12] = '{1'b0,8'h00,8'h00,7'h00,1'b0,8'h01,8'h0F, 1'b1,8'h02,8'h22,7'h02,3'd2,1'b1,1'b0,1'b0,8'h00,1'b0,8'h00};
    tbl[13] = '{1'b0,8'h00,8'h00,7'h00,1'b0,8'h0A,8'h2A, 1'b1,8'h0A,8'h33,7'h04,3'd1,1'b1,1'b0,1'b1,8'h44,1'b1,8'h44};
    tbl[14] = '{1'b0,8'h00,8'h00,7'h00,1'b0,8'h0A,8'h2A, 1'b1,8'h0A,8'h44,7'h08,3'd0,1'b1,1'b0,1'b1,8'h44,1'b1,8'h44};
    tbl[15] = '{1'b0,8'h00,8'h00,7'h00,1'b0,8'h0A,8'h2A, 1'b0,8'h0A,8'h44,7'h08,3'd0,1'b1,1'b1,1'b0,8'h00,1'b0,8'h00};
    tbl[16] = '{1'b1,8'h03,8'h55,7'h12,1'b1,8'h03,8'h03, 1'b0,8'h0A,8'h44,7'h08,3'd0,1'b1,1'b1,1'b0,8'h00,1'b0,8'h00};
    tbl[17] = '{1'b0,8'h00,8'h00,7'h00,1'b1,8'h03,8'h05, 1'b0,8'h0A,8'h44,7'h08,3'd1,1'b1,1'b0,1'b1,8'h12,1'b0,8'h00};

    drive(1'b0, 8'h00, 8'h00, 7'h00, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    #12 rst = 1'b0;

    // Directed table: inputs applied after the falling edge, outputs checked before the next rise.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].f, tbl[i].h, tbl[i].r1, tbl[i].r2);
      #1;
      check($sformatf("v%0d_we", i),    32'(regWriteEnable), 32'(tbl[i].we));
      check($sformatf("v%0d_a3", i),    32'(A3),             32'(tbl[i].a3));
      check($sformatf("v%0d_wd", i),    32'(WriteData),      32'(tbl[i].wd));
      check($sformatf("v%0d_fl", i),    32'(Flag_input),     32'(tbl[i].fl));
      check($sformatf("v%0d_cnt", i),   32'(count),          32'(tbl[i].cnt));
      check($sformatf("v%0d_rdy", i),   32'(inReady),        32'(tbl[i].rdy));
      check($sformatf("v%0d_empty", i), 32'(empty),          32'(tbl[i].emp));
      check($sformatf("v%0d_hit1", i),  32'(byp1Hit),        32'(tbl[i].h1));
      check($sformatf("v%0d_d1", i),    32'(byp1Data),       32'(bd(tbl[i].d1)));
      check($sformatf("v%0d_hit2", i),  32'(byp2Hit),        32'(tbl[i].h2));
      check($sformatf("v%0d_d2", i),    32'(byp2Data),       32'(bd(tbl[i].d2)));
    end

    // Fill to 4 under hold (one entry already queued), then pop while offering a push into a full queue.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 8'(8'h10 + i), 8'(8'h60 + i), 7'h01, 1'b1, 8'h00, 8'h00);
    end
    @(negedge clk);
    drive(1'b1, 8'h1F, 8'hEE, 7'h7E, 1'b0, 8'h00, 8'h00);
    #1;
    check("full_cnt", 32'(count), 32'd4);
    check("full_rdy_during_pop", 32'(inReady), 32'd0);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 7'h00, 1'b1, 8'h1F, 8'h00);
    #1;
    check("nopass_cnt", 32'(count), 32'd3);
    check("nopass_we", 32'(regWriteEnable), 32'd1);
    check("nopass_a3", 32'(A3), 32'h03);
    check("nopass_hit", 32'(byp1Hit), 32'd0);

    // Asynchronous reset with a strobe in flight.
    rst = 1'b1;
    #1;
    check("rst_we", 32'(regWriteEnable), 32'd0);
    check("rst_cnt", 32'(count), 32'd0);
    check("rst_rdy", 32'(inReady), 32'd1);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_a3", 32'(A3), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_we = 1'b0; m_a3 = 8'h00; m_wd = 8'h00; m_fl = 7'h00;

    // Random traffic against the reference model.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 1)),
            {3'($urandom), 5'($urandom_range(0, 7))},
            8'($urandom), 7'($urandom),
            1'($urandom_range(0, 9) < 3),
            {3'($urandom), 5'($urandom_range(0, 7))},
            {3'($urandom_range(0, 1)), 5'($urandom_range(0, 7))});
      #1;
      model_byp(rdAddr1, eh1, ed1);
      model_byp(rdAddr2, eh2, ed2);
      check("r_we",    32'(regWriteEnable), 32'(m_we));
      check("r_a3",    32'(A3),             32'(m_a3));
      check("r_wd",    32'(WriteData),      32'(m_wd));
      check("r_fl",    32'(Flag_input),     32'(m_fl));
      check("r_cnt",   32'(count),          32'(mq.size()));
      check("r_rdy",   32'(inReady),        32'(mq.size() < 4));
      check("r_empty", 32'(empty),          32'((mq.size() == 0) && !m_we));
      check("r_hit1",  32'(byp1Hit),        32'(eh1));
      check("r_d1",    32'(byp1Data),       32'(bd(ed1)));
      check("r_hit2",  32'(byp2Hit),        32'(eh2));
      check("r_d2",    32'(byp2Data),       32'(bd(ed2)));
      @(posedge clk);
      pu = inValid && (mq.size() < 4);
      po = !hold && (mq.size() > 0);
      if (po) begin
        e = mq.pop_front();
        m_we = 1'b1; m_a3 = e.a; m_wd = e.d; m_fl = e.f;
      end else begin
        m_we = 1'b0;
      end
      if (pu) begin
        mq.push_back('{inAddr, inData, inFlags});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
